// File: rtl/ram_bist_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_bist_if : start/result and RAM-side signals of ram_bist_ctrl   |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
interface ram_bist_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 8
);
  logic                  start;
  logic                  abort;
  logic [DATA_WIDTH-1:0] pattern;
  logic [ADDR_WIDTH-1:0] ram_wr_address;
  logic [ADDR_WIDTH-1:0] ram_rd_address;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  ram_write;
  logic                  ram_read;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [CNT_WIDTH-1:0]  fail_count;
  logic [ADDR_WIDTH-1:0] first_fail_addr;

  modport slave (
    input  start, abort, pattern, ram_data_out,
    output ram_wr_address, ram_rd_address, ram_data_in, ram_write, ram_read,
           busy, done, pass, fail_count, first_fail_addr
  );

  modport master (
    output start, abort, pattern, ram_data_out,
    input  ram_wr_address, ram_rd_address, ram_data_in, ram_write, ram_read,
           busy, done, pass, fail_count, first_fail_addr
  );
endinterface
`default_nettype wire

// File: rtl/ram_bist_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram_bist_ctrl : March-style BIST controller for a 1R1W RAM         |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module ram_bist_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 8
) (
  input wire logic  clk,
  input wire logic  reset,
  ram_bist_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_BG     = 3'd1,
    S_RW_UP    = 3'd2,
    S_RW_DN    = 3'd3,
    S_R_BG     = 3'd4,
    S_CHK_LAST = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  phase_q, phase_d;
  logic [DATA_WIDTH-1:0] bg_q, bg_d;
  logic [CNT_WIDTH-1:0]  fail_count_q, fail_count_d;
  logic [ADDR_WIDTH-1:0] first_fail_addr_q, first_fail_addr_d;
  logic                  pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  write_q, write_d;
  logic                  read_q, read_d;

  logic                  busy_w;
  logic                  cmp_en;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic [ADDR_WIDTH-1:0] cmp_addr;

  assign busy_w = (state_q == S_W_BG) || (state_q == S_RW_UP) || (state_q == S_RW_DN) ||
                  (state_q == S_R_BG) || (state_q == S_CHK_LAST);

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    phase_d           = phase_q;
    bg_d              = bg_q;
    fail_count_d      = fail_count_q;
    first_fail_addr_d = first_fail_addr_q;
    pass_d            = pass_q;
    wr_addr_d         = wr_addr_q;
    rd_addr_d         = rd_addr_q;
    din_d             = din_q;
    write_d           = 1'b0;
    read_d            = 1'b0;
    cmp_en            = 1'b0;
    cmp_exp           = bg_q;
    cmp_addr          = addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d           = S_W_BG;
          bg_d              = bus.pattern;
          fail_count_d      = '0;
          first_fail_addr_d = '0;
          pass_d            = 1'b0;
          addr_d            = '0;
          phase_d           = 1'b0;
        end
      end
      S_W_BG: begin
        addr_d = addr_q + ADDR_ONE;
        if (addr_q == ADDR_MAX) state_d = S_RW_UP;
      end
      S_RW_UP: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cmp_en = 1'b1;
          if (addr_q == ADDR_MAX) state_d = S_RW_DN;
          else                    addr_d  = addr_q + ADDR_ONE;
        end
      end
      S_RW_DN: begin
        phase_d = ~phase_q;
        cmp_exp = ~bg_q;
        if (phase_q) begin
          cmp_en = 1'b1;
          if (addr_q == '0) state_d = S_R_BG;
          else              addr_d  = addr_q - ADDR_ONE;
        end
      end
      S_R_BG: begin
        // Data returns a cycle late, so each cycle checks the previous address.
        cmp_en   = (addr_q != '0);
        cmp_addr = addr_q - ADDR_ONE;
        addr_d   = addr_q + ADDR_ONE;
        if (addr_q == ADDR_MAX) state_d = S_CHK_LAST;
      end
      S_CHK_LAST: begin
        cmp_en   = 1'b1;
        cmp_addr = addr_q - ADDR_ONE;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (busy_w && bus.abort) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
      cmp_en  = 1'b0;
    end

    if (cmp_en && (bus.ram_data_out != cmp_exp)) begin
      if (fail_count_q == '0)     first_fail_addr_d = cmp_addr;
      if (fail_count_q != CNT_MAX) fail_count_d     = fail_count_q + CNT_ONE;
    end

    if (state_d == S_DONE) pass_d = (fail_count_d == '0);

    // RAM strobes are registered, so they are derived from the state being entered.
    unique case (state_d)
      S_W_BG: begin
        write_d   = 1'b1;
        wr_addr_d = addr_d;
        din_d     = bg_d;
      end
      S_RW_UP, S_RW_DN: begin
        if (!phase_d) begin
          read_d    = 1'b1;
          rd_addr_d = addr_d;
        end else begin
          write_d   = 1'b1;
          wr_addr_d = addr_d;
          din_d     = (state_d == S_RW_UP) ? ~bg_d : bg_d;
        end
      end
      S_R_BG: begin
        read_d    = 1'b1;
        rd_addr_d = addr_d;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      addr_q            <= '0;
      phase_q           <= 1'b0;
      bg_q              <= '0;
      fail_count_q      <= '0;
      first_fail_addr_q <= '0;
      pass_q            <= 1'b0;
      wr_addr_q         <= '0;
      rd_addr_q         <= '0;
      din_q             <= '0;
      write_q           <= 1'b0;
      read_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      phase_q           <= phase_d;
      bg_q              <= bg_d;
      fail_count_q      <= fail_count_d;
      first_fail_addr_q <= first_fail_addr_d;
      pass_q            <= pass_d;
      wr_addr_q         <= wr_addr_d;
      rd_addr_q         <= rd_addr_d;
      din_q             <= din_d;
      write_q           <= write_d;
      read_q            <= read_d;
    end
  end

  assign bus.ram_wr_address  = wr_addr_q;
  assign bus.ram_rd_address  = rd_addr_q;
  assign bus.ram_data_in     = din_q;
  assign bus.ram_write       = write_q;
  assign bus.ram_read        = read_q;
  assign bus.busy            = busy_w;
  assign bus.done            = (state_q == S_DONE);
  assign bus.pass            = pass_q;
  assign bus.fail_count      = fail_count_q;
  assign bus.first_fail_addr = first_fail_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
`default_nettype none
// Bench for ram_bist_ctrl: directed + randomized March runs against an array-level reference model.
module tb_ram_bist_ctrl;
  localparam int AW = 4;
  localparam int DW = 64;
  localparam int DEPTH = 16;
  localparam int TEST_CYC = 6 * DEPTH + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(8)) bus ();
  ram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(4)) bus4 ();

  ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4));

  int vectors = 0;
  int miscompares = 0;
  int conflicts = 0;
  int idle_acc = 0;

  bit fault_en = 1'b0;
  int fault_addr = 0;
  int fault_bit = 0;
  bit fault_val = 1'b0;

  function automatic logic [DW-1:0] stored(input int a, input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    if (fault_en && a == fault_addr) r[fault_bit] = fault_val;
    return r;
  endfunction

  // RAM with optional stuck-at cell; second controller sees a RAM that always reads all-ones
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata = '0;
  always @(posedge clk) begin
    if (bus.ram_write) mem[int'(bus.ram_wr_address)] <= stored(int'(bus.ram_wr_address), bus.ram_data_in);
    if (bus.ram_read)  rdata <= mem[int'(bus.ram_rd_address)];
  end
  assign bus.ram_data_out  = rdata;
  assign bus4.ram_data_out = '1;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ram_read && bus.ram_write) conflicts++;
      if (!bus.busy && (bus.ram_read || bus.ram_write)) idle_acc++;
      if (bus4.ram_read && bus4.ram_write) conflicts++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // March sequence over a plain array: w(BG); up r(BG)w(INV); down r(INV)w(BG); up r(BG)
  task automatic predict(input logic [DW-1:0] bg, input bit ones, output int cnt, output int first);
    logic [DW-1:0] m [DEPTH];
    logic [DW-1:0] rd;
    cnt = 0;
    first = 0;
    for (int a = 0; a < DEPTH; a++) m[a] = stored(a, bg);
    for (int a = 0; a < DEPTH; a++) begin
      rd = ones ? '1 : m[a];
      if (rd !== bg) begin if (cnt == 0) first = a; cnt++; end
      m[a] = stored(a, ~bg);
    end
    for (int a = DEPTH - 1; a >= 0; a--) begin
      rd = ones ? '1 : m[a];
      if (rd !== ~bg) begin if (cnt == 0) first = a; cnt++; end
      m[a] = stored(a, bg);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd = ones ? '1 : m[a];
      if (rd !== bg) begin if (cnt == 0) first = a; cnt++; end
    end
  endtask

  task automatic wait_done(input bit use4, output int bc, output bit ok);
    bc = 0;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (use4 ? bus4.busy : bus.busy) bc++;
      if (use4 ? bus4.done : bus.done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_test(input string tag, input logic [DW-1:0] pat, input bit fen,
                          input int fa, input int fb, input bit fv);
    int exp_cnt, exp_first, bc;
    bit ok;
    fault_en = fen; fault_addr = fa; fault_bit = fb; fault_val = fv;
    predict(pat, 1'b0, exp_cnt, exp_first);
    if (exp_cnt > 255) exp_cnt = 255;
    bus.pattern = pat;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.pattern = {$urandom, $urandom};
    wait_done(1'b0, bc, ok);
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(bc), 64'(TEST_CYC));
    chk({tag, "_pass"}, 64'(bus.pass), 64'(exp_cnt == 0));
    chk({tag, "_fail_count"}, 64'(bus.fail_count), 64'(exp_cnt));
    chk({tag, "_first_fail"}, 64'(bus.first_fail_addr), 64'(exp_first));
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(bus.done), 64'd0);
    chk({tag, "_pass_hold"}, 64'(bus.pass), 64'(exp_cnt == 0));
  endtask

  initial begin
    int bc, acc, dn, e_cnt, e_first;
    bit ok;
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.pattern = '0;
    bus4.start = 1'b0; bus4.abort = 1'b0; bus4.pattern = '0;

    #1 reset = 1'b1;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_write", 64'(bus.ram_write), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_done", 64'(bus.done), 64'd0);
    chk("idle_pass", 64'(bus.pass), 64'd0);
    chk("idle_fcnt", 64'(bus.fail_count), 64'd0);
    chk("idle_ffa", 64'(bus.first_fail_addr), 64'd0);
    chk("idle_rw", 64'({bus.ram_read, bus.ram_write}), 64'd0);
    chk("idle_addr", 64'({bus.ram_wr_address, bus.ram_rd_address}), 64'd0);
    chk("idle_din", bus.ram_data_in, 64'd0);

    run_test("a5", 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 0, 0, 1'b0);
    run_test("sa0_a5b0", 64'd0, 1'b1, 5, 0, 1'b0);
    for (int i = 0; i < 3; i++) run_test("rnd_clean", {$urandom, $urandom}, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_test("rnd_fault", {$urandom, $urandom}, 1'b1, int'($urandom_range(0, DEPTH - 1)),
               int'($urandom_range(0, DW - 1)), 1'(int'($urandom_range(0, 1))));
    fault_en = 1'b0;

    // abort on busy cycle 20
    bus.pattern = {$urandom, $urandom};
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    chk("abort_busy_before", 64'(bus.busy), 64'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_pass", 64'(bus.pass), 64'd0);
    chk("abort_fcnt", 64'(bus.fail_count), 64'd0);
    acc = 0; dn = 0;
    repeat (20) begin
      if (bus.ram_read || bus.ram_write) acc++;
      if (bus.done || bus.busy) dn++;
      @(negedge clk);
    end
    chk("abort_no_access", 64'(acc), 64'd0);
    chk("abort_stays_idle", 64'(dn), 64'd0);

    // reset on busy cycle 50
    bus.pattern = 64'h0123_4567_89AB_CDEF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (49) @(negedge clk);
    chk("rst50_busy_before", 64'(bus.busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst50_flags", 64'({bus.busy, bus.done, bus.pass, bus.ram_read, bus.ram_write}), 64'd0);
    chk("rst50_fcnt_ffa", 64'({bus.fail_count, bus.first_fail_addr}), 64'd0);
    chk("rst50_addr", 64'({bus.ram_wr_address, bus.ram_rd_address}), 64'd0);
    chk("rst50_din", bus.ram_data_in, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst50_idle_after", 64'(bus.busy), 64'd0);
    run_test("after_rst", 64'hFFFF_0000_FFFF_0000, 1'b0, 0, 0, 1'b0);

    // start held high: back-to-back tests
    bus.pattern = {$urandom, $urandom};
    bus.start = 1'b1;
    @(negedge clk);
    wait_done(1'b0, bc, ok);
    chk("held_first_done", 64'(ok), 64'd1);
    chk("held_first_busy", 64'(bc), 64'(TEST_CYC));
    @(negedge clk);
    chk("held_gap_idle", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("held_second_start", 64'(bus.busy), 64'd1);
    wait_done(1'b0, bc, ok);
    bus.start = 1'b0;
    chk("held_second_done", 64'(ok), 64'd1);
    chk("held_second_busy", 64'(bc), 64'(TEST_CYC));
    chk("held_second_pass", 64'(bus.pass), 64'd1);
    repeat (3) @(negedge clk);
    chk("held_released_idle", 64'(bus.busy), 64'd0);

    // 4-bit counter against an all-ones RAM
    predict('0, 1'b1, e_cnt, e_first);
    if (e_cnt > 15) e_cnt = 15;
    bus4.pattern = '0;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    wait_done(1'b1, bc, ok);
    chk("sat_done", 64'(ok), 64'd1);
    chk("sat_busy", 64'(bc), 64'(TEST_CYC));
    chk("sat_fcnt", 64'(bus4.fail_count), 64'(e_cnt));
    chk("sat_ffa", 64'(bus4.first_fail_addr), 64'(e_first));
    chk("sat_pass", 64'(bus4.pass), 64'd0);
    @(negedge clk);

    chk("rd_wr_conflicts", 64'(conflicts), 64'd0);
    chk("access_when_idle", 64'(idle_acc), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
